// File: rtl/ecc_core_arbiter.sv
// ecc_core_arbiter: round-robin sharing of one point-multiplication core between two requesters
// Ports: clk/n_rst (sync active-high reset); req0/k0/x0/y0 and req1/k1/x1/y1 requester channels;
// done0/done1/err/res_x/res_y completion; busy/owner status; core_start/core_k/core_x/core_y to core;
// core_done/core_skx/core_sky from core.
module ecc_core_arbiter #(
    parameter int WIDTH          = 164,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] k0,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic             req1,
    input  logic [WIDTH-1:0] k1,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    output logic             done0,
    output logic             done1,
    output logic             err,
    output logic [WIDTH-1:0] res_x,
    output logic [WIDTH-1:0] res_y,
    output logic             busy,
    output logic             owner,
    output logic             core_start,
    output logic [WIDTH-1:0] core_k,
    output logic [WIDTH-1:0] core_x,
    output logic [WIDTH-1:0] core_y,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_skx,
    input  logic [WIDTH-1:0] core_sky
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESULT} state_t;
    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             done0_q, done1_q, err_q, busy_q, owner_q, start_q;
    logic [WIDTH-1:0] res_x_q, res_y_q, k_q, x_q, y_q;
    logic             gnt;
    // Under contention the channel that did not win last time is served.
    assign gnt = (req0 & req1) ? ~owner_q : req1;
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            owner_q <= 1'b1;
            start_q <= 1'b0;
            res_x_q <= '0;
            res_y_q <= '0;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            start_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: if (req0 | req1) begin
                    owner_q <= gnt;
                    k_q     <= gnt ? k1 : k0;
                    x_q     <= gnt ? x1 : x0;
                    y_q     <= gnt ? y1 : y0;
                    start_q <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= LAUNCH;
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // Incremented value reaching TIMEOUT_CYCLES-1 aborts; core_done takes priority.
                    if (core_done || cnt_q == CW'(TIMEOUT_CYCLES - 2)) begin
                        res_x_q <= core_done ? core_skx : '0;
                        res_y_q <= core_done ? core_sky : '0;
                        err_q   <= ~core_done;
                        done0_q <= ~owner_q;
                        done1_q <= owner_q;
                        state_q <= RESULT;
                    end
                end
                RESULT: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign err        = err_q;
    assign res_x      = res_x_q;
    assign res_y      = res_y_q;
    assign busy       = busy_q;
    assign owner      = owner_q;
    assign core_start = start_q;
    assign core_k     = k_q;
    assign core_x     = x_q;
    assign core_y     = y_q;
endmodule
